uart_rx: RTL

UART receiver for the serial-port link, the receive-side counterpart of the team's UART transmitter. Receives 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity) from an asynchronous serial line. Outputs each received byte with a one-cycle done strobe. Flags framing errors. Sits between the board RX pin and the byte-level consumer logic, in the same clock domain as the transmitter.

---
 rtl/uart_rx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling, done/error strobes.
// Framing errors park the FSM until the line returns high, so a break cannot produce repeated frames.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxEnable,
  input  logic       uartRxBit,
  output logic [7:0] uartOutByte,
  output logic       uartRxDone,
  output logic       uartRxError
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);

  localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rx_sync;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      out_byte_q, out_byte_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  assign rx_sync = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      sync_q     <= 2'b11;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      out_byte_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], uartRxBit};
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      out_byte_q <= out_byte_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    out_byte_d = out_byte_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    if (!rxEnable) begin
      // Disabling aborts any frame in progress without a strobe.
      state_d   = StIdle;
      cnt_d     = '0;
      bit_idx_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d     = '0;
          bit_idx_d = '0;
          if (!rx_sync) state_d = StStart;
        end
        StStart: begin
          if (cnt_q == HalfLast) begin
            cnt_d   = '0;
            state_d = rx_sync ? StIdle : StData;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == BitLast) begin
            cnt_d              = '0;
            shift_d[bit_idx_q] = rx_sync;
            bit_idx_d          = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_d = StStop;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (cnt_q == BitLast) begin
            cnt_d = '0;
            if (rx_sync) begin
              out_byte_d = shift_q;
              done_d     = 1'b1;
              state_d    = StIdle;
            end else begin
              error_d = 1'b1;
              state_d = StWaitIdle;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StWaitIdle: begin
          cnt_d = '0;
          if (rx_sync) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign uartOutByte = out_byte_q;
  assign uartRxDone  = done_q;
  assign uartRxError = error_q;

endmodule
